// File: rtl/llm_quant_pkg.sv
// Shared quantizer types and arithmetic: FSM states, qmax, divider length, round/saturate.
// Pure definitions, no latency or backpressure of its own.
package llm_quant_pkg;

   typedef enum logic [1:0] {COLLECT, DIVIDE, EMIT} state_t;

   function automatic int qmax(input int width);
      return (1 << (width - 1)) - 1;
   endfunction

   // One quotient bit per cycle across the whole (qmax << frac) dividend.
   function automatic int div_cycles(input int qw, input int frac);
      return qw - 1 + frac;
   endfunction

   localparam int DIV_CYCLES = div_cycles(8, 16);

   function automatic logic signed [63:0] round_q(input logic signed [63:0] p, input int frac);
      logic signed [63:0] half;
      half = (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
      return (p + half) >>> frac;
   endfunction

   function automatic logic is_sat(input logic signed [63:0] p, input int frac, input int qw);
      logic signed [63:0] q;
      logic signed [63:0] qm;
      q  = round_q(p, frac);
      qm = 64'(qmax(qw));
      return (q > qm) || (q < -qm);
   endfunction

   // Symmetric clamp: -qmax-1 is never produced.
   function automatic logic signed [31:0] round_sat(input logic signed [63:0] p, input int frac,
                                                    input int qw);
      logic signed [63:0] q;
      logic signed [63:0] qm;
      q  = round_q(p, frac);
      qm = 64'(qmax(qw));
      if (q > qm)
         return 32'(qm);
      else if (q < -qm)
         return 32'(-qm);
      else
         return 32'(q);
   endfunction

endpackage

// File: rtl/serial_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses DIVIDEND_W cycles after start.
// No backpressure: start is honoured whenever asserted and restarts any division in flight.
module serial_restoring_divider #(
   parameter int DIVIDEND_W = 23,
   parameter int DIVISOR_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient
);

   localparam int CW = $clog2(DIVIDEND_W + 1);

   logic [DIVISOR_W-1:0]  rem;
   logic [DIVISOR_W-1:0]  dvs;
   logic [DIVIDEND_W-1:0] quo;
   logic [CW-1:0]         count;
   logic [DIVISOR_W:0]    shifted;
   logic                  ge;

   assign busy     = (count != '0);
   assign quotient = quo;

   always_comb begin
      shifted = {rem, quo[DIVIDEND_W-1]};
      ge      = (shifted >= {1'b0, dvs});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem   <= '0;
         dvs   <= '0;
         quo   <= '0;
         count <= '0;
         done  <= 1'b0;
      end else if (start) begin
         rem   <= '0;
         dvs   <= divisor;
         quo   <= dividend;
         count <= CW'(DIVIDEND_W);
         done  <= 1'b0;
      end else if (busy) begin
         // Dividend bits shift out of quo's top as quotient bits shift into its bottom.
         quo   <= {quo[DIVIDEND_W-2:0], ge};
         rem   <= ge ? DIVISOR_W'(shifted - {1'b0, dvs}) : DIVISOR_W'(shifted);
         count <= count - CW'(1);
         done  <= (count == CW'(1));
      end else begin
         done  <= 1'b0;
      end
   end

endmodule

// File: rtl/block_max_quantizer.sv
// Block max-abs int8 quantizer; first code DIV_CYCLES+2 cycles after the last input beat, then one beat/cycle.
// Input stalls during DIVIDE/EMIT; outputs hold while valid&!ready. BLOCK_MAX_QUANTIZER_SAT_COUNT_EN adds sat_count.
module block_max_quantizer
   import llm_quant_pkg::*;
#(
   parameter int IN_WIDTH           = 16,
   parameter int IN_SIZE            = 4,
   parameter int IN_PARALLELISM     = 1,
   parameter int BLOCK_BEATS        = 4,
   parameter int QUANTIZATION_WIDTH = 8,
   parameter int MAX_NUM_WIDTH      = 32,
   parameter int SCALE_FRAC_WIDTH   = 16
) (
   input  logic                                                   clk,
   input  logic                                                   rst,
   input  logic [IN_WIDTH*IN_PARALLELISM*IN_SIZE-1:0]             data_in,
   input  logic                                                   data_in_valid,
   output logic                                                   data_in_ready,
   output logic [QUANTIZATION_WIDTH*IN_PARALLELISM*IN_SIZE-1:0]   data_out,
   output logic [MAX_NUM_WIDTH-1:0]                               max_num,
   output logic                                                   data_out_last,
   output logic                                                   data_out_valid,
   input  logic                                                   data_out_ready
`ifdef BLOCK_MAX_QUANTIZER_SAT_COUNT_EN
  ,output logic [$clog2(BLOCK_BEATS*IN_PARALLELISM*IN_SIZE+1)-1:0] sat_count
`endif
);

   localparam int N      = IN_PARALLELISM * IN_SIZE;
   localparam int QW     = QUANTIZATION_WIDTH;
   localparam int SFW    = SCALE_FRAC_WIDTH;
   localparam int DIV_W  = div_cycles(QW, SFW);
   localparam int PW     = IN_WIDTH + SFW + QW;
   localparam int CNT_W  = $clog2(BLOCK_BEATS + 1);
   localparam int IDX_W  = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
   localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(qmax(QW)) << SFW;

   state_t                    state, state_nxt;
   logic [CNT_W-1:0]          cnt;
   logic [IN_WIDTH-1:0]       max_q, max_nxt;
   logic [IN_WIDTH-1:0]       elem_i, mag;
   logic [IN_WIDTH-1:0]       elem_o;
   logic signed [PW-1:0]      p;
   logic [DIV_W-1:0]          scale_q;
   logic [DIV_W-1:0]          quotient;
   logic                      scale_vld;
   logic                      div_busy, div_done;
   logic [N*IN_WIDTH-1:0]     buffer [BLOCK_BEATS];
   logic [IDX_W-1:0]          ld_idx;
   logic [N*QW-1:0]           q_nxt;
   logic                      last_nxt;
   logic                      accept, block_in_done, out_hs;
   logic                      load_first, load_next, block_end;

   assign data_in_ready = (state == COLLECT);
   assign max_num       = MAX_NUM_WIDTH'(max_q);

   assign accept        = data_in_valid && data_in_ready;
   assign block_in_done = accept && (cnt == CNT_W'(BLOCK_BEATS - 1));
   assign out_hs        = data_out_valid && data_out_ready;
   assign load_first    = (state == DIVIDE) && scale_vld;
   assign load_next     = (state == EMIT) && out_hs && !data_out_last;
   assign block_end     = (state == EMIT) && out_hs && data_out_last;

   assign ld_idx   = load_first ? '0 : IDX_W'(cnt);
   assign last_nxt = load_first ? (BLOCK_BEATS == 1) : (cnt == CNT_W'(BLOCK_BEATS - 1));

   // Magnitudes are taken as IN_WIDTH-bit unsigned so the most negative input maps to 2^(IN_WIDTH-1).
   always_comb begin
      max_nxt = max_q;
      elem_i  = '0;
      mag     = '0;
      for (int e = 0; e < N; e++) begin
         elem_i = data_in[e*IN_WIDTH +: IN_WIDTH];
         mag    = elem_i[IN_WIDTH-1] ? (~elem_i + IN_WIDTH'(1)) : elem_i;
         if (mag > max_nxt)
            max_nxt = mag;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= COLLECT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (block_in_done) state_nxt = DIVIDE;
         DIVIDE:  if (load_first)    state_nxt = EMIT;
         EMIT:    if (block_end)     state_nxt = COLLECT;
         default:                    state_nxt = COLLECT;
      endcase
   end

   // The divider starts on the same edge that takes the last beat, using the final block max.
   serial_restoring_divider #(
      .DIVIDEND_W (DIV_W),
      .DIVISOR_W  (IN_WIDTH)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (block_in_done),
      .dividend (DIVIDEND),
      .divisor  (max_nxt),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (quotient)
   );

   always_ff @(posedge clk) begin
      if (accept)
         buffer[IDX_W'(cnt)] <= data_in;
   end

   always_comb begin
      q_nxt  = '0;
      elem_o = '0;
      p      = '0;
      for (int e = 0; e < N; e++) begin
         elem_o = buffer[ld_idx][e*IN_WIDTH +: IN_WIDTH];
         p      = PW'($signed(elem_o)) * PW'($signed({1'b0, scale_q}));
         q_nxt[e*QW +: QW] = QW'(round_sat(64'(p), SFW, QW));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         max_q     <= '0;
         scale_q   <= '0;
         scale_vld <= 1'b0;
      end else begin
         if (accept) begin
            max_q <= max_nxt;
            cnt   <= block_in_done ? '0 : cnt + CNT_W'(1);
         end
         if (div_done) begin
            scale_q   <= (max_q == '0) ? '0 : quotient;
            scale_vld <= 1'b1;
         end else if (load_first) begin
            scale_vld <= 1'b0;
         end
         if (load_first)
            cnt <= CNT_W'(1);
         else if (load_next)
            cnt <= cnt + CNT_W'(1);
         else if (block_end) begin
            cnt   <= '0;
            max_q <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out       <= '0;
         data_out_valid <= 1'b0;
         data_out_last  <= 1'b0;
      end else if (load_first || load_next) begin
         data_out       <= q_nxt;
         data_out_valid <= 1'b1;
         data_out_last  <= last_nxt;
      end else if (block_end) begin
         data_out_valid <= 1'b0;
         data_out_last  <= 1'b0;
      end
   end

`ifdef BLOCK_MAX_QUANTIZER_SAT_COUNT_EN
   localparam int SAT_W = $clog2(BLOCK_BEATS * N + 1);

   logic [SAT_W-1:0]     sat_beat;
   logic [IN_WIDTH-1:0]  elem_s;
   logic signed [PW-1:0] p_s;

   always_comb begin
      sat_beat = '0;
      elem_s   = '0;
      p_s      = '0;
      for (int e = 0; e < N; e++) begin
         elem_s   = buffer[ld_idx][e*IN_WIDTH +: IN_WIDTH];
         p_s      = PW'($signed(elem_s)) * PW'($signed({1'b0, scale_q}));
         sat_beat = sat_beat + SAT_W'(is_sat(64'(p_s), SFW, QW));
      end
   end

   // Restarts on each block's first beat so the total stays visible until the next block emits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         sat_count <= '0;
      else if (load_first)
         sat_count <= sat_beat;
      else if (load_next)
         sat_count <= sat_count + sat_beat;
   end
`endif

endmodule

// File: tb/tb_block_max_quantizer.sv
// Randomized and directed checks of block_max_quantizer (BLOCK_BEATS=2, IN_SIZE=4) against an arithmetic model.
// Covers reset, latency, rounding, -32768 symmetry, zero blocks, output backpressure and reset during DIVIDE.
module tb_block_max_quantizer;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] data_in;
   logic        data_in_valid;
   logic        data_in_ready;
   logic [31:0] data_out;
   logic [31:0] max_num;
   logic        data_out_last;
   logic        data_out_valid;
   logic        data_out_ready;
`ifdef BLOCK_MAX_QUANTIZER_SAT_COUNT_EN
   logic [3:0]  sat_count;
`endif

   int total = 0;
   int bad   = 0;
   int blk [2][4];

   always #5 clk = ~clk;

   block_max_quantizer #(
      .IN_WIDTH           (16),
      .IN_SIZE            (4),
      .IN_PARALLELISM     (1),
      .BLOCK_BEATS        (2),
      .QUANTIZATION_WIDTH (8),
      .MAX_NUM_WIDTH      (32),
      .SCALE_FRAC_WIDTH   (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_in_ready  (data_in_ready),
      .data_out       (data_out),
      .max_num        (max_num),
      .data_out_last  (data_out_last),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready)
`ifdef BLOCK_MAX_QUANTIZER_SAT_COUNT_EN
     ,.sat_count      (sat_count)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_scale(input int mx);
      if (mx == 0) return 0;
      return (127 * 65536) / mx;
   endfunction

   // Round half up in real-number terms, then clamp symmetrically to +-127.
   function automatic int ref_code(input int x, input int sc, output bit sat);
      longint n;
      longint q;
      n = longint'(x) * longint'(sc) + 64'sd32768;
      q = n / 65536;
      if (n < 0 && (n % 65536) != 0) q = q - 1;
      sat = (q > 127) || (q < -127);
      if (q > 127)  q = 127;
      if (q < -127) q = -127;
      return int'(q);
   endfunction

   task automatic send_beat(input int b);
      for (int e = 0; e < 4; e++) data_in[e*16 +: 16] = 16'(blk[b][e]);
      data_in_valid = 1'b1;
      for (int k = 0; k < 50 && !data_in_ready; k++) tick();
      if (!data_in_ready) chk("in_rdy_wait", {63'd0, data_in_ready}, 64'd1);
      tick();
      data_in_valid = 1'b0;
   endtask

   task automatic run_block(input int stall);
      int          mx, sc, lat, nsat, a, q;
      bit          s;
      logic [31:0] expc [2];
      mx = 0;
      nsat = 0;
      for (int b = 0; b < 2; b++)
         for (int e = 0; e < 4; e++) begin
            a = (blk[b][e] < 0) ? -blk[b][e] : blk[b][e];
            if (a > mx) mx = a;
         end
      sc = ref_scale(mx);
      for (int b = 0; b < 2; b++)
         for (int e = 0; e < 4; e++) begin
            q = ref_code(blk[b][e], sc, s);
            nsat += int'(s);
            expc[b][e*8 +: 8] = 8'(q);
         end

      data_out_ready = 1'b0;
      send_beat(0);
      send_beat(1);
      chk("in_rdy_divide", {63'd0, data_in_ready}, 64'd0);
      lat = 0;
      while (!data_out_valid && lat < 100) begin
         tick();
         lat++;
      end
      chk("latency", 64'(lat), 64'd25);
      chk("beat0_dat", {32'd0, data_out}, {32'd0, expc[0]});
      chk("beat0_max", {32'd0, max_num}, 64'(mx));
      chk("beat0_last", {63'd0, data_out_last}, 64'd0);

      for (int k = 0; k < stall; k++) begin
         tick();
         chk("hold_vld", {63'd0, data_out_valid}, 64'd1);
         chk("hold_dat", {32'd0, data_out}, {32'd0, expc[0]});
         chk("hold_max", {32'd0, max_num}, 64'(mx));
         chk("hold_last", {63'd0, data_out_last}, 64'd0);
         chk("hold_in_rdy", {63'd0, data_in_ready}, 64'd0);
      end

      data_out_ready = 1'b1;
      tick();
      chk("beat1_vld", {63'd0, data_out_valid}, 64'd1);
      chk("beat1_dat", {32'd0, data_out}, {32'd0, expc[1]});
      chk("beat1_max", {32'd0, max_num}, 64'(mx));
      chk("beat1_last", {63'd0, data_out_last}, 64'd1);
      chk("beat1_in_rdy", {63'd0, data_in_ready}, 64'd0);
`ifdef BLOCK_MAX_QUANTIZER_SAT_COUNT_EN
      chk("sat_count", {60'd0, sat_count}, 64'(nsat));
`endif
      tick();
      chk("post_vld", {63'd0, data_out_valid}, 64'd0);
      chk("post_in_rdy", {63'd0, data_in_ready}, 64'd1);
      chk("post_max", {32'd0, max_num}, 64'd0);
      data_out_ready = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      data_in        = '0;
      data_in_valid  = 1'b0;
      data_out_ready = 1'b0;
      #3 rst = 1'b0;
      tick();
      tick();
      chk("rst_in_rdy", {63'd0, data_in_ready}, 64'd1);
      chk("rst_vld", {63'd0, data_out_valid}, 64'd0);
      chk("rst_dat", {32'd0, data_out}, 64'd0);
      chk("rst_max", {32'd0, max_num}, 64'd0);
      chk("rst_last", {63'd0, data_out_last}, 64'd0);
      rst = 1'b1;
      tick();

      blk = '{'{100, -50, 25, 0}, '{200, -200, 1, 0}};
      run_block(0);

      blk = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}};
      run_block(0);

      blk = '{'{-32768, 0, 0, 0}, '{0, 0, 0, 0}};
      run_block(0);

      blk = '{'{100, -50, 25, 0}, '{200, -200, 1, 0}};
      run_block(5);

      // Reset in the middle of DIVIDE, then the same block run cleanly.
      blk = '{'{1234, -4321, 77, -9}, '{30000, -2, 555, 8191}};
      send_beat(0);
      send_beat(1);
      for (int k = 0; k < 10; k++) tick();
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_vld", {63'd0, data_out_valid}, 64'd0);
      chk("mid_rst_in_rdy", {63'd0, data_in_ready}, 64'd1);
      chk("mid_rst_max", {32'd0, max_num}, 64'd0);
      chk("mid_rst_dat", {32'd0, data_out}, 64'd0);
      chk("mid_rst_last", {63'd0, data_out_last}, 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      tick();
      run_block(0);

      for (int t = 0; t < 8; t++) begin
         for (int b = 0; b < 2; b++)
            for (int e = 0; e < 4; e++) begin
               blk[b][e] = int'($urandom_range(0, 65535)) - 32768;
               if (t % 2 == 1) blk[b][e] = blk[b][e] >>> 7;
            end
         run_block(int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
